// File: rtl/flick_conditioner.sv
// flick_conditioner: synchronises, debounces and stretches the raw flick
// push-button before it reaches the bound flasher's flick input.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-low
//   flick_raw  in   raw button pad, asynchronous and bouncy
//   enable     in   0 holds the conditioner idle (synchronous)
//   flick      out  debounced, stretched level (high >= MIN_HOLD cycles)
//   flick_rise out  1-cycle pulse on the edge flick goes 0->1
//   flick_fall out  1-cycle pulse on the edge flick goes 1->0
//   press_cnt  out  accepted presses, wraps, cleared only by rst
module flick_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int MIN_HOLD    = 32,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flick_raw,
    input  logic             enable,
    output logic             flick,
    output logic             flick_rise,
    output logic             flick_fall,
    output logic [CNT_W-1:0] press_cnt
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(MIN_HOLD + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ARM_HI,
        HELD,
        ARM_LO,
        STRETCH
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    state_e                 state_q,     state_d;
    logic [DB_W-1:0]        db_cnt_q,    db_cnt_d;
    logic [HOLD_W-1:0]      hold_cnt_q,  hold_cnt_d;
    logic                   flick_q,     flick_d;
    logic                   rise_q,      rise_d;
    logic                   fall_q,      fall_d;
    logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;

    logic [DB_W-1:0]        db_inc;
    logic [HOLD_W-1:0]      hold_inc;

    // Synchroniser keeps running even while disabled so that re-enabling
    // starts from a settled view of the pad.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], flick_raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    assign db_inc = db_cnt_q + DB_ONE;

    // Hold time saturates so a long press never wraps back below the
    // minimum-width threshold.
    assign hold_inc = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q
                                               : hold_cnt_q + HOLD_ONE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            db_cnt_q    <= '0;
            hold_cnt_q  <= '0;
            flick_q     <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            flick_q     <= flick_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            press_cnt_q <= press_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        flick_d     = flick_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        press_cnt_d = press_cnt_q;

        if (!enable) begin
            // Silent drop: no fall pulse, counter untouched.
            state_d    = IDLE;
            db_cnt_d   = '0;
            hold_cnt_d = '0;
            flick_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    flick_d = 1'b0;
                    if (s) begin
                        state_d  = ARM_HI;
                        db_cnt_d = DB_ONE;
                    end
                end

                ARM_HI: begin
                    if (!s) begin
                        state_d  = IDLE;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        state_d     = HELD;
                        db_cnt_d    = '0;
                        hold_cnt_d  = '0;
                        flick_d     = 1'b1;
                        rise_d      = 1'b1;
                        press_cnt_d = press_cnt_q + 1'b1;
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end

                HELD: begin
                    hold_cnt_d = hold_inc;
                    if (!s) begin
                        state_d  = ARM_LO;
                        db_cnt_d = DB_ONE;
                    end
                end

                ARM_LO: begin
                    hold_cnt_d = hold_inc;
                    if (s) begin
                        state_d  = HELD;
                        db_cnt_d = '0;
                    end else if (db_cnt_q == DB_LAST) begin
                        db_cnt_d = '0;
                        if (hold_cnt_q >= HOLD_LAST) begin
                            state_d    = IDLE;
                            hold_cnt_d = '0;
                            flick_d    = 1'b0;
                            fall_d     = 1'b1;
                        end else begin
                            // Released too early: keep flick high
                            // until the minimum width has elapsed.
                            state_d = STRETCH;
                        end
                    end else begin
                        db_cnt_d = db_inc;
                    end
                end

                STRETCH: begin
                    hold_cnt_d = hold_inc;
                    if (s) begin
                        // Re-press merges into the current pulse.
                        state_d  = HELD;
                        db_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                        flick_d    = 1'b0;
                        fall_d     = 1'b1;
                    end
                end

                default: begin
                    state_d    = IDLE;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                    flick_d    = 1'b0;
                end
            endcase
        end
    end

    assign flick      = flick_q;
    assign flick_rise = rise_q;
    assign flick_fall = fall_q;
    assign press_cnt  = press_cnt_q;

endmodule
